imem_loader: RTL and testbench

//  Boot-time program loader sitting directly upstream of riscv_processor's instruction memory.

---
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time program loader for the instruction memory of
//               riscv_processor. Accepts a valid/ready stream of words,
//               writes them sequentially from word address 0, then compares
//               a trailing checksum word against the running sum of the
//               program. The core is held in reset until a load verifies.
// Ports       : clk, reset (sync, active-low)
//               start, word_count          - load request and program length
//               in_valid, in_data, in_ready - input word stream
//               mem_we, mem_addr, mem_wdata - instruction-memory write port
//               core_reset                 - active-high reset to the core
//               busy, done, error          - status (LOAD/CHECK, RUN, FAIL)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Memory depth expressed at word_count width (one extra bit so that a
    // full-depth program of 2**ADDR_WIDTH words is representable).
    localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH:0]   w_cnt_nxt;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   w_len_nxt;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] w_sum_nxt;

    logic w_in_load;
    logic w_xfer;

    assign w_in_load = (r_state == S_LOAD);
    assign in_ready  = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign w_xfer    = in_valid && in_ready;

    // Write port is combinational so memory captures the word on the same
    // edge as the handshake; address/data are forced to 0 outside LOAD.
    assign mem_we     = w_in_load && w_xfer;
    assign mem_addr   = w_in_load ? r_cnt[ADDR_WIDTH-1:0] : '0;
    assign mem_wdata  = w_in_load ? in_data : '0;

    assign core_reset = (r_state != S_RUN);
    assign busy       = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign done       = (r_state == S_RUN);
    assign error      = (r_state == S_FAIL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_sum   <= w_sum_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_sum_nxt   = r_sum;
        unique case (r_state)
            S_IDLE, S_RUN, S_FAIL: begin
                if (start) begin
                    w_len_nxt = word_count;
                    w_cnt_nxt = '0;
                    w_sum_nxt = '0;
                    if (word_count > c_DEPTH) begin
                        w_state_nxt = S_FAIL;
                    end else if (word_count == '0) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_sum_nxt = r_sum + in_data;
                    w_cnt_nxt = r_cnt + c_ONE;
                    // Last program word; cnt never reaches len so the
                    // address stays within the memory.
                    if (r_cnt == (r_len - c_ONE)) begin
                        w_state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (w_xfer) begin
                    w_state_nxt = (in_data == r_sum) ? S_RUN : S_FAIL;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  core_reset;
    logic                  busy;
    logic                  done;
    logic                  error;

    int checks = 0;
    int errors = 0;

    // Write log captured at the falling edge, away from the active edge.
    logic [ADDR_WIDTH-1:0] addr_log[$];
    logic [DATA_WIDTH-1:0] data_log[$];
    int                    stall_writes = 0;

    imem_loader #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .word_count(word_count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_reset(core_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            addr_log.push_back(mem_addr);
            data_log.push_back(mem_wdata);
            if (in_valid !== 1'b1) stall_writes++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_WIDTH:0] wc);
        start      = 1'b1;
        word_count = wc;
        tick();
        start      = 1'b0;
    endtask

    // Present one word and hold it until the handshake edge has passed.
    task automatic send(input logic [DATA_WIDTH-1:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=%h expected=%h", in_ready, 1'b1);
        end
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic clear_log();
        addr_log.delete();
        data_log.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
        check({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
        check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_done"},       {31'd0, done},       32'd0);
        check({tag, "_error"},      {31'd0, error},      32'd0);
        check({tag, "_mem_addr"},   {24'd0, mem_addr},   32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,           32'd0);
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] sum;
        logic [DATA_WIDTH-1:0] w;
        logic [DATA_WIDTH-1:0] words[256];
        int                    bad_order;

        reset      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();

        // ---- 1: two-word load with correct checksum ----
        clear_log();
        do_start(9'd2);
        check("t1_busy",     {31'd0, busy},     32'd1);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        send(32'h005303b3);
        send(32'h00628633);
        check("t1_check_busy", {31'd0, busy},       32'd1);
        check("t1_check_cr",   {31'd0, core_reset}, 32'd1);
        send(32'h00b589e6);
        check("t1_done",       {31'd0, done},       32'd1);
        check("t1_core_reset", {31'd0, core_reset}, 32'd0);
        check("t1_error",      {31'd0, error},      32'd0);
        check("t1_nwrites",    addr_log.size(),     32'd2);
        if (addr_log.size() == 2) begin
            check("t1_addr0", {24'd0, addr_log[0]}, 32'd0);
            check("t1_addr1", {24'd0, addr_log[1]}, 32'd1);
            check("t1_data0", data_log[0], 32'h005303b3);
            check("t1_data1", data_log[1], 32'h00628633);
        end

        // ---- 2: restart from RUN, bad checksum ----
        clear_log();
        do_start(9'd2);
        check("t2_core_reset_restart", {31'd0, core_reset}, 32'd1);
        send(32'h005303b3);
        send(32'h00628633);
        send(32'h00000000);
        check("t2_error",      {31'd0, error},      32'd1);
        check("t2_done",       {31'd0, done},       32'd0);
        check("t2_core_reset", {31'd0, core_reset}, 32'd1);
        check("t2_nwrites",    addr_log.size(),     32'd2);

        // ---- 3: empty program, then oversize program ----
        clear_log();
        do_start(9'd0);
        check("t3_check_busy",  {31'd0, busy},     32'd1);
        check("t3_check_ready", {31'd0, in_ready}, 32'd1);
        send(32'h00000000);
        check("t3_done",    {31'd0, done},   32'd1);
        check("t3_nwrites", addr_log.size(), 32'd0);
        do_start(9'd257);
        check("t3_oversize_error", {31'd0, error}, 32'd1);
        check("t3_oversize_busy",  {31'd0, busy},  32'd0);

        // ---- 4: full-depth load with random stalls ----
        clear_log();
        stall_writes = 0;
        sum = '0;
        do_start(9'd256);
        for (int i = 0; i < 256; i++) begin
            w        = $urandom;
            words[i] = w;
            sum      = sum + w;
            repeat ($urandom_range(0, 2)) tick();
            send(w);
        end
        check("t4_in_check", {31'd0, busy}, 32'd1);
        repeat (3) tick();
        check("t4_stall_hold", {31'd0, busy}, 32'd1);
        send(sum);
        check("t4_done",         {31'd0, done},   32'd1);
        check("t4_nwrites",      addr_log.size(), 32'd256);
        check("t4_stall_writes", stall_writes,    32'd0);
        bad_order = 0;
        if (addr_log.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                if (addr_log[i] !== i[7:0] || data_log[i] !== words[i]) bad_order++;
            end
        end
        check("t4_order", bad_order, 32'd0);

        // ---- 5: reset mid-load, then reload from address 0 ----
        clear_log();
        do_start(9'd5);
        send(32'h11111111);
        send(32'h22222222);
        send(32'h33333333);
        reset = 1'b0;
        tick();
        check_reset_outputs("t5_rst");
        reset = 1'b1;
        tick();
        clear_log();
        do_start(9'd2);
        send(32'h00000005);
        send(32'h00000007);
        send(32'h0000000c);
        check("t5_done",    {31'd0, done},   32'd1);
        check("t5_nwrites", addr_log.size(), 32'd2);
        if (addr_log.size() == 2) begin
            check("t5_addr0", {24'd0, addr_log[0]}, 32'd0);
        end

        // ---- 6: restart from RUN with start held during LOAD ----
        clear_log();
        do_start(9'd1);
        check("t6_core_reset", {31'd0, core_reset}, 32'd1);
        start      = 1'b1;
        word_count = 9'd0;
        tick();
        tick();
        check("t6_held_busy",  {31'd0, busy},     32'd1);
        check("t6_held_ready", {31'd0, in_ready}, 32'd1);
        send(32'hdeadbeef);
        check("t6_in_check", {31'd0, busy}, 32'd1);
        start = 1'b0;
        send(32'hdeadbeef);
        check("t6_done",    {31'd0, done},   32'd1);
        check("t6_nwrites", addr_log.size(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
